// File: rtl/sig_gen_pkg.sv
// -----------------------------------------------------------------------------
// sig_gen_pkg
// Shared constants for the signal generator sweep logic.
//   FW_W_DEF / DW_W_DEF : default frequency-word and dwell-counter widths
//   state_t             : 3-bit sweep FSM state
//   ST_*                : state encodings (ST_DOWN only reachable when the
//                         SWEEP_PINGPONG_EN build option is defined)
// -----------------------------------------------------------------------------
package sig_gen_pkg;

  localparam int FW_W_DEF = 32;
  localparam int DW_W_DEF = 24;
  localparam int ST_W     = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DWELL = 3'd1;
  localparam state_t ST_STEP  = 3'd2;
  localparam state_t ST_WRAP  = 3'd3;
  localparam state_t ST_DOWN  = 3'd4;

endpackage

// File: rtl/sweep_dwell_timer.sv
// -----------------------------------------------------------------------------
// sweep_dwell_timer
// Down-counter that measures how long the sweep holds one frequency word.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val into the counter (has priority over dec)
//   load_val   : dwell length in cycles, already forced to >= 1
//   dec        : count down by one (never below 1)
//   cnt        : current count
//   expire     : decrement that brings the count to 1 is happening now
//   at_one     : count is 1, i.e. this is the final cycle of the dwell
// -----------------------------------------------------------------------------
module sweep_dwell_timer #(
  parameter int DW_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DW_W-1:0] load_val,
  input  logic            dec,
  output logic [DW_W-1:0] cnt,
  output logic            expire,
  output logic            at_one
);

  localparam logic [DW_W-1:0] CNT_ONE = DW_W'(1);
  localparam logic [DW_W-1:0] CNT_TWO = DW_W'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt > CNT_ONE)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign expire = dec && (cnt == CNT_TWO);
  assign at_one = (cnt == CNT_ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Drives the DDS frequency control word through a linear sweep
// f_start -> f_stop in f_step increments, holding each word for `dwell`
// cycles. Single-shot or continuous; optional up/down ping-pong.
//
// Build option: define SWEEP_PINGPONG_EN to add the DOWN state and the
// decrementing datapath; otherwise the sweep restarts at f_start.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begin sweep (ignored while busy)
//   stop         : one-cycle pulse, abort sweep (wins over start)
//   cont         : 1 = repeat forever, 0 = single shot (sampled at start)
//   f_start      : first frequency word
//   f_stop       : final frequency word
//   f_step       : increment per step
//   dwell        : cycles per step, 0 treated as 1
//   fword        : frequency word to the phase accumulator
//   fword_vld    : one-cycle pulse whenever fword changes
//   busy         : high while the FSM is not IDLE
//   done         : one-cycle pulse when a single-shot sweep completes
//   cfg_err      : one-cycle pulse when start is rejected (f_step==0 or
//                  f_start>=f_stop)
//   state_dbg    : current FSM state (sig_gen_pkg encoding)
//
// Timing: every word, including the last one, is held exactly dwell cycles.
// DWELL covers all but the final cycle of a hold; STEP, WRAP and DOWN each
// act on the final cycle, so leaving a state never stretches the hold.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
  import sig_gen_pkg::*;
#(
  parameter int FW_W = FW_W_DEF,
  parameter int DW_W = DW_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            cont,
  input  logic [FW_W-1:0] f_start,
  input  logic [FW_W-1:0] f_stop,
  input  logic [FW_W-1:0] f_step,
  input  logic [DW_W-1:0] dwell,
  output logic [FW_W-1:0] fword,
  output logic            fword_vld,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic [ST_W-1:0] state_dbg
);

  localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);

  state_t          state;
  state_t          state_nxt;

  // Shadow copies of the configuration taken when a sweep starts
  logic [FW_W-1:0] f_start_s;
  logic [FW_W-1:0] f_stop_s;
  logic [FW_W-1:0] f_step_s;
  logic [DW_W-1:0] dwell_s;
  logic            cont_s;
  logic            shadow_load;

  logic [FW_W-1:0] fword_nxt;
  logic            vld_nxt;
  logic            done_nxt;
  logic            cfg_err_nxt;

  logic            tmr_load;
  logic [DW_W-1:0] tmr_load_val;
  logic            tmr_dec;
  logic [DW_W-1:0] tmr_cnt;
  logic            tmr_expire;
  logic            tmr_at_one;

  logic [DW_W-1:0] dwell_in;
  logic            cfg_ok;
  logic            dwell_one;

  logic [FW_W:0]   up_sum;
  logic            up_sat;
  logic [FW_W-1:0] up_word;
  state_t          up_state;
  state_t          start_state;
  state_t          restart_state;

  assign dwell_in  = (dwell == '0) ? DW_ONE : dwell;
  assign cfg_ok    = (f_step != '0) && (f_start < f_stop);
  assign dwell_one = (dwell_s == DW_ONE);

  // Up step in FW_W+1 bits so a wrap past all-ones shows up as a carry.
  assign up_sum  = {1'b0, fword} + {1'b0, f_step_s};
  assign up_sat  = up_sum[FW_W] || (up_sum[FW_W-1:0] > f_stop_s);
  assign up_word = up_sat ? f_stop_s : up_sum[FW_W-1:0];

  // With a one-cycle dwell there is no DWELL cycle, so the state that follows
  // a new word is the one that acts on it. A word equal to f_stop always ends
  // in WRAP; a saturated word goes straight to WRAP which runs the full dwell.
  assign up_state = dwell_one ? ((up_word == f_stop_s) ? ST_WRAP : ST_STEP)
                              : (up_sat ? ST_WRAP : ST_DWELL);
  assign start_state   = (dwell_in == DW_ONE) ? ST_STEP : ST_DWELL;
  assign restart_state = dwell_one ? ST_STEP : ST_DWELL;

`ifdef SWEEP_PINGPONG_EN
  logic [FW_W:0]   dn_diff;
  logic            dn_sat;
  logic [FW_W-1:0] dn_word;

  // Down step; the top bit is the borrow when f_step exceeds fword.
  assign dn_diff = {1'b0, fword} - {1'b0, f_step_s};
  assign dn_sat  = dn_diff[FW_W] || (dn_diff[FW_W-1:0] < f_start_s);
  assign dn_word = dn_sat ? f_start_s : dn_diff[FW_W-1:0];
`endif

  sweep_dwell_timer #(
    .DW_W (DW_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .expire   (tmr_expire),
    .at_one   (tmr_at_one)
  );

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fword     <= '0;
      fword_vld <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      f_start_s <= '0;
      f_stop_s  <= '0;
      f_step_s  <= '0;
      dwell_s   <= '0;
      cont_s    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fword     <= fword_nxt;
      fword_vld <= vld_nxt;
      done      <= done_nxt;
      cfg_err   <= cfg_err_nxt;
      if (shadow_load) begin
        f_start_s <= f_start;
        f_stop_s  <= f_stop;
        f_step_s  <= f_step;
        dwell_s   <= dwell_in;
        cont_s    <= cont;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && cfg_ok) state_nxt = start_state;
        end
        ST_DWELL: begin
          if (tmr_expire) state_nxt = (fword == f_stop_s) ? ST_WRAP : ST_STEP;
        end
        ST_STEP: begin
          state_nxt = up_state;
        end
        ST_WRAP: begin
          if (tmr_at_one) begin
`ifdef SWEEP_PINGPONG_EN
            state_nxt = ST_DOWN;
`else
            state_nxt = cont_s ? restart_state : ST_IDLE;
`endif
          end
        end
`ifdef SWEEP_PINGPONG_EN
        ST_DOWN: begin
          if (tmr_at_one && (fword == f_start_s)) begin
            state_nxt = cont_s ? up_state : ST_IDLE;
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fword_nxt    = fword;
    vld_nxt      = 1'b0;
    done_nxt     = 1'b0;
    cfg_err_nxt  = 1'b0;
    shadow_load  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = dwell_s;
    tmr_dec      = 1'b0;
    if (!stop) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow_load = 1'b1;
            if (cfg_ok) begin
              fword_nxt    = f_start;
              vld_nxt      = 1'b1;
              tmr_load     = 1'b1;
              tmr_load_val = dwell_in;
            end else begin
              cfg_err_nxt = 1'b1;
            end
          end
        end
        ST_DWELL: begin
          tmr_dec = 1'b1;
        end
        ST_STEP: begin
          fword_nxt = up_word;
          vld_nxt   = 1'b1;
          tmr_load  = 1'b1;
        end
        ST_WRAP: begin
          if (tmr_at_one) begin
`ifdef SWEEP_PINGPONG_EN
            fword_nxt = dn_word;
            vld_nxt   = 1'b1;
            tmr_load  = 1'b1;
`else
            if (cont_s) begin
              fword_nxt = f_start_s;
              vld_nxt   = 1'b1;
              tmr_load  = 1'b1;
            end else begin
              done_nxt = 1'b1;
            end
`endif
          end else begin
            tmr_dec = 1'b1;
          end
        end
`ifdef SWEEP_PINGPONG_EN
        ST_DOWN: begin
          if (tmr_at_one) begin
            if (fword == f_start_s) begin
              if (cont_s) begin
                fword_nxt = up_word;
                vld_nxt   = 1'b1;
                tmr_load  = 1'b1;
              end else begin
                done_nxt = 1'b1;
              end
            end else begin
              fword_nxt = dn_word;
              vld_nxt   = 1'b1;
              tmr_load  = 1'b1;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Self-checking bench for dds_sweep_ctrl (default build, up-only sweep).
// Expected frequency words are produced by a small sweep model and queued
// when a sweep is started; they are popped as fword_vld pulses appear.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

  localparam int FW_W = 32;
  localparam int DW_W = 24;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            cont = 1'b0;
  logic [FW_W-1:0] f_start = '0;
  logic [FW_W-1:0] f_stop = '0;
  logic [FW_W-1:0] f_step = '0;
  logic [DW_W-1:0] dwell = '0;
  logic [FW_W-1:0] fword;
  logic            fword_vld;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [2:0]      state_dbg;

  dds_sweep_ctrl #(.FW_W(FW_W), .DW_W(DW_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .fword     (fword),
    .fword_vld (fword_vld),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [FW_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_vld_cyc = 0;
  bit have_last = 1'b0;

  // Reference sweep: start word, then add step until f_stop is reached or
  // passed (carry included); a pass saturates to f_stop.
  function automatic void push_sweep(input logic [FW_W-1:0] fs,
                                     input logic [FW_W-1:0] fe,
                                     input logic [FW_W-1:0] st);
    logic [FW_W:0]   sum;
    logic [FW_W-1:0] w;
    w = fs;
    exp_q.push_back(w);
    while (w != fe) begin
      sum = {1'b0, w} + {1'b0, st};
      if (sum > {1'b0, fe}) w = fe;
      else w = sum[FW_W-1:0];
      exp_q.push_back(w);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_cfg(input logic [FW_W-1:0] fs, input logic [FW_W-1:0] fe,
                         input logic [FW_W-1:0] st, input logic [DW_W-1:0] dw,
                         input logic c);
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    cont    = c;
  endtask

  // Returns at the negedge one cycle after the edge that sampled start.
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches outputs once per cycle (negedge). Pops and compares every fword,
  // checks hold length between words and the done pulse. Stops after n_stop
  // words (0 = run until done) or flags a timeout.
  task automatic observe(input int max_cyc, input int gap, input bit fresh,
                         input int n_stop, input logic [FW_W-1:0] final_w);
    int seen;
    bit fin;
    logic [FW_W-1:0] exp_w;
    seen = 0;
    fin = 1'b0;
    if (fresh) have_last = 1'b0;
    for (int i = 0; i < max_cyc && !fin; i++) begin
      if (fword_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vld_extra: fword=%0h with no expected value", fword);
        end else begin
          exp_w = exp_q.pop_front();
          if (fword !== exp_w) begin
            errors++;
            $display("FAIL fword_value: got %0h expected %0h", fword, exp_w);
          end
        end
        if (fresh && seen == 0) begin
          checks++;
          if (i != 0) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles expected 1", i + 1);
          end
        end else if (have_last) begin
          checks++;
          if (cyc - last_vld_cyc != gap) begin
            errors++;
            $display("FAIL dwell_gap: got %0d cycles expected %0d", cyc - last_vld_cyc, gap);
          end
        end
        last_vld_cyc = cyc;
        have_last = 1'b1;
        seen++;
        if (n_stop != 0 && seen == n_stop) fin = 1'b1;
      end
      if (!fin && done) begin
        checks++;
        if (cyc - last_vld_cyc != gap) begin
          errors++;
          $display("FAIL done_gap: got %0d cycles expected %0d", cyc - last_vld_cyc, gap);
        end
        checks++;
        if (busy !== 1'b0 || fword !== final_w) begin
          errors++;
          $display("FAIL done_state: busy=%0b fword=%0h expected busy=0 fword=%0h", busy, fword, final_w);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL seq_short: %0d expected words never produced", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_width: done=%0b one cycle later, expected 0", done);
        end
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: no completion within %0d cycles", max_cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fword !== '0 || fword_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_err !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: fword=%0h vld=%0b busy=%0b done=%0b cfg_err=%0b state=%0d expected all 0",
               fword, fword_vld, busy, done, cfg_err, state_dbg);
    end
  endtask

  task automatic test_single_shot;
    set_cfg(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    push_sweep(32'd100, 32'd130, 32'd10);
    pulse_start();
    observe(200, 4, 1'b1, 0, 32'd130);
    repeat (3) @(negedge clk);
    checks++;
    if (fword !== 32'd130 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: fword=%0h busy=%0b expected 82 and 0", fword, busy);
    end
  endtask

  task automatic test_saturate;
    set_cfg(32'd100, 32'd125, 32'd10, 24'd2, 1'b0);
    push_sweep(32'd100, 32'd125, 32'd10);
    pulse_start();
    observe(200, 2, 1'b1, 0, 32'd125);
  endtask

  task automatic test_carry;
    // dwell of 0 behaves as a one-cycle dwell
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 1'b0);
    push_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20);
    pulse_start();
    observe(50, 1, 1'b1, 0, 32'hFFFF_FFFF);
  endtask

  task automatic test_continuous_stop;
    bit bad;
    set_cfg(32'd0, 32'd20, 32'd10, 24'd1, 1'b1);
    repeat (3) push_sweep(32'd0, 32'd20, 32'd10);
    pulse_start();
    // Live config changes mid-sweep must not affect the running sweep
    set_cfg(32'd77, 32'd5, 32'd3, 24'd9, 1'b0);
    observe(100, 1, 1'b1, 7, 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || fword !== 32'd0 || fword_vld !== 1'b0) begin
      errors++;
      $display("FAIL stop_response: busy=%0b fword=%0h vld=%0b expected 0 0 0", busy, fword, fword_vld);
    end
    exp_q.delete();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fword_vld || done || busy || fword !== 32'd0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stop_quiet: activity after stop, expected frozen idle outputs");
    end
  endtask

  task automatic test_cfg_err;
    logic [FW_W-1:0] prev;
    prev = fword;
    set_cfg(32'd10, 32'd90, 32'd0, 24'd3, 1'b0);
    pulse_start();
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || fword !== prev || fword_vld !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_step0: cfg_err=%0b busy=%0b fword=%0h vld=%0b expected 1 0 %0h 0",
               cfg_err, busy, fword, fword_vld, prev);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_width: cfg_err=%0b expected 0", cfg_err);
    end
    set_cfg(32'd50, 32'd50, 32'd5, 24'd3, 1'b0);
    pulse_start();
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || fword !== prev) begin
      errors++;
      $display("FAIL cfg_err_equal: cfg_err=%0b busy=%0b fword=%0h expected 1 0 %0h",
               cfg_err, busy, fword, prev);
    end
  endtask

  task automatic test_start_stop_same;
    set_cfg(32'd200, 32'd300, 32'd25, 24'd2, 1'b0);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || fword_vld !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_same: busy=%0b vld=%0b cfg_err=%0b expected 0 0 0", busy, fword_vld, cfg_err);
    end
  endtask

  task automatic test_back_to_back;
    // A second start while busy (with a different, valid config) is ignored
    set_cfg(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    push_sweep(32'd100, 32'd130, 32'd10);
    pulse_start();
    observe(100, 4, 1'b1, 2, 32'd130);
    set_cfg(32'd5, 32'd9, 32'd1, 24'd1, 1'b0);
    pulse_start();
    observe(100, 4, 1'b0, 0, 32'd130);
  endtask

  task automatic test_reset_mid;
    set_cfg(32'd1000, 32'd2000, 32'd100, 24'd10, 1'b0);
    exp_q.push_back(32'd1000);
    pulse_start();
    observe(20, 10, 1'b1, 1, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fword !== '0 || busy !== 1'b0 || fword_vld !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: fword=%0h busy=%0b vld=%0b done=%0b expected all 0", fword, busy, fword_vld, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_shot();
    test_saturate();
    test_carry();
    test_continuous_stop();
    test_cfg_err();
    test_start_stop_same();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
